// File: rtl/entropy_encode_ac_run_codebook_if.sv
`default_nettype none
// ============================================================================
// Module   : entropy_encode_ac_run_codebook_if
// Brief    : Coefficient-in / codeword-out valid-ready bundle for the AC run
//            codebook encoder. master = upstream/downstream side, slave = encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface entropy_encode_ac_run_codebook_if #(
    parameter int COEFF_W = 20,
    parameter int CW_W    = 32,
    parameter int LEN_W   = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [COEFF_W-1:0] in_coeff;
    logic               in_last;

    logic               out_valid;
    logic               out_ready;
    logic [CW_W-1:0]    out_code;
    logic [LEN_W-1:0]   out_len;
    logic               out_last;

    modport master (
        output in_valid,
        output in_coeff,
        output in_last,
        input  in_ready,
        input  out_valid,
        input  out_code,
        input  out_len,
        input  out_last,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_coeff,
        input  in_last,
        output in_ready,
        output out_valid,
        output out_code,
        output out_len,
        output out_last,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/entropy_encode_ac_run_codebook.sv
`default_nettype none
// ============================================================================
// Module   : entropy_encode_ac_run_codebook
// Brief    : AC zero-run VLC encoder; adaptive rice/exp-golomb codebook chosen
//            by the previous run. Define AC_RUN_BITCOUNT_EN to add seg_bits.
// Revision : 1.0 - initial release
// ============================================================================
module entropy_encode_ac_run_codebook #(
    parameter int COEFF_W = 20,
    parameter int RUN_W   = 12,
    parameter int CW_W    = 32,
    parameter int LEN_W   = 6
) (
    input  wire                             clk,
    input  wire                             reset,
    entropy_encode_ac_run_codebook_if.slave bus,
`ifdef AC_RUN_BITCOUNT_EN
    output logic [15:0]                     seg_bits,
`endif
    output logic                            err_run_ovf
);

    localparam logic [RUN_W-1:0] c_RUN_MAX  = '1;
    localparam logic [RUN_W-1:0] c_PREV_RST = RUN_W'(4);
    localparam int               c_AW       = 32;
    localparam int               c_PEW      = RUN_W + 4;

    // ------------------------------------------------------------------------
    // Codebook table indexed by min(prev_run, 15)
    // ------------------------------------------------------------------------
    function automatic logic [7:0] f_codebook(input logic [3:0] idx);
        logic [7:0] cb;
        case (idx)
            4'd0, 4'd1:                             cb = 8'h06;
            4'd2, 4'd3:                             cb = 8'h05;
            4'd4:                                   cb = 8'h04;
            4'd5, 4'd6, 4'd7, 4'd8:                 cb = 8'h29;
            4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14: cb = 8'h28;
            default:                                cb = 8'h4C;
        endcase
        return cb;
    endfunction

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] r_prev_run;
    logic             r_err;

    logic             r_s1_valid;
    logic             r_s1_last;
    logic             r_s1_marker;
    logic [RUN_W-1:0] r_s1_run;
    logic [7:0]       r_s1_cb;

    logic             r_out_valid;
    logic [CW_W-1:0]  r_out_code;
    logic [LEN_W-1:0] r_out_len;
    logic             r_out_last;

    logic             w_nz;
    logic             w_in_fire;
    logic             w_in_ready;
    logic             w_out_load;
    logic [c_PEW-1:0] w_prev_ext;
    logic [3:0]       w_cb_idx;
    logic [7:0]       w_cb;

    logic [1:0]       w_sw;
    logic [2:0]       w_eo;
    logic [2:0]       w_ro;
    logic [c_AW-1:0]  w_v;
    logic [c_AW-1:0]  w_first_exp;
    logic [c_AW-1:0]  w_u;
    logic [4:0]       w_e;
    logic [c_AW-1:0]  w_code_full;
    logic [c_AW-1:0]  w_len_full;
    logic [CW_W-1:0]  w_code;
    logic [LEN_W-1:0] w_len;

    // ------------------------------------------------------------------------
    // Handshake: stage 1 drains into the output register when it is free or
    // emptying; zero beats are gated too so the run never outruns the pipe.
    // ------------------------------------------------------------------------
    assign w_nz       = (bus.in_coeff != COEFF_W'(0));
    assign w_out_load = r_s1_valid && (!r_out_valid || bus.out_ready);
    assign w_in_ready = !r_s1_valid || w_out_load;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    assign w_prev_ext = {4'd0, r_prev_run};
    assign w_cb_idx   = (w_prev_ext > c_PEW'(15)) ? 4'd15 : w_prev_ext[3:0];
    assign w_cb       = f_codebook(w_cb_idx);

    // ------------------------------------------------------------------------
    // Run / previous-run tracking and sticky overflow flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run      <= '0;
            r_prev_run <= c_PREV_RST;
            r_err      <= 1'b0;
        end else if (w_in_fire) begin
            if (bus.in_last) begin
                r_run      <= '0;
                r_prev_run <= c_PREV_RST;
            end else if (w_nz) begin
                r_run      <= '0;
                r_prev_run <= r_run;
            end else if (r_run != c_RUN_MAX) begin
                r_run      <= r_run + RUN_W'(1);
            end
            if (!w_nz && (r_run == c_RUN_MAX)) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: captured run + codebook (or end-of-segment marker)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_marker <= 1'b0;
            r_s1_run    <= '0;
            r_s1_cb     <= 8'd0;
        end else if (w_in_fire && (w_nz || bus.in_last)) begin
            r_s1_valid  <= 1'b1;
            r_s1_last   <= bus.in_last;
            r_s1_marker <= !w_nz;
            r_s1_run    <= r_run;
            r_s1_cb     <= w_cb;
        end else if (w_out_load) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: codeword arithmetic
    // ------------------------------------------------------------------------
    assign w_sw        = r_s1_cb[1:0];
    assign w_eo        = r_s1_cb[4:2];
    assign w_ro        = r_s1_cb[7:5];
    assign w_v         = c_AW'(r_s1_run);
    assign w_first_exp = (c_AW'(w_sw) + c_AW'(1)) << w_ro;
    assign w_u         = w_v - w_first_exp + (c_AW'(1) << w_eo);

    always_comb begin
        w_e = 5'd0;
        for (int i = 0; i < c_AW; i++) begin
            if (w_u[i]) begin
                w_e = 5'(i);
            end
        end
    end

    always_comb begin
        w_code_full = '0;
        w_len_full  = '0;
        if (r_s1_marker) begin
            w_code_full = '0;
            w_len_full  = '0;
        end else if (w_v < w_first_exp) begin
            // rice: unary quotient, stop bit, ro-bit remainder
            w_code_full = (c_AW'(1) << w_ro) | (w_v & ((c_AW'(1) << w_ro) - c_AW'(1)));
            w_len_full  = (w_v >> w_ro) + c_AW'(1) + c_AW'(w_ro);
        end else begin
            w_code_full = w_u;
            w_len_full  = (c_AW'(w_e) << 1) + c_AW'(1) + c_AW'(w_sw) - c_AW'(w_eo);
        end
    end

    assign w_code = CW_W'(w_code_full);
    assign w_len  = LEN_W'(w_len_full);

    // ------------------------------------------------------------------------
    // Output register: holds while out_valid && !out_ready
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_len   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_code  <= w_code;
            r_out_len   <= w_len;
            r_out_last  <= r_s1_last;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_out_code;
    assign bus.out_len   = r_out_len;
    assign bus.out_last  = r_out_last;
    assign err_run_ovf   = r_err;

`ifdef AC_RUN_BITCOUNT_EN
    // ------------------------------------------------------------------------
    // Segment bit accumulator; zeroed the cycle after the last token leaves
    // ------------------------------------------------------------------------
    logic [15:0] r_seg_bits;
    logic        r_seg_done;
    logic        w_out_fire;

    assign w_out_fire = r_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_bits <= 16'd0;
            r_seg_done <= 1'b0;
        end else begin
            if (w_out_fire) begin
                r_seg_bits <= (r_seg_done ? 16'd0 : r_seg_bits) + 16'(r_out_len);
            end else if (r_seg_done) begin
                r_seg_bits <= 16'd0;
            end
            r_seg_done <= w_out_fire && r_out_last;
        end
    end

    assign seg_bits = r_seg_bits;
`endif

endmodule
`default_nettype wire

// File: tb/tb_entropy_encode_ac_run_codebook.sv
`default_nettype none
// ============================================================================
// Module   : tb_entropy_encode_ac_run_codebook
// Brief    : Directed + scoreboard bench for the AC run codebook encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_entropy_encode_ac_run_codebook;

    localparam int COEFF_W = 20;
    localparam int RUN_W   = 12;
    localparam int CW_W    = 32;
    localparam int LEN_W   = 6;
    localparam int RUN_MAX = (1 << RUN_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic err_run_ovf;
`ifdef AC_RUN_BITCOUNT_EN
    logic [15:0] seg_bits;
`endif

    always #5 clk = ~clk;

    entropy_encode_ac_run_codebook_if #(
        .COEFF_W (COEFF_W),
        .CW_W    (CW_W),
        .LEN_W   (LEN_W)
    ) bus ();

    entropy_encode_ac_run_codebook #(
        .COEFF_W (COEFF_W),
        .RUN_W   (RUN_W),
        .CW_W    (CW_W),
        .LEN_W   (LEN_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
`ifdef AC_RUN_BITCOUNT_EN
        .seg_bits    (seg_bits),
`endif
        .err_run_ovf (err_run_ovf)
    );

    typedef struct packed {
        logic [CW_W-1:0]  code;
        logic [LEN_W-1:0] len;
        logic             last;
    } tok_t;

    tok_t       exp_q[$];
    tok_t       mon_got;
    tok_t       mon_want;
    int         total = 0;
    int         bad   = 0;
    int         m_run;
    int         m_prev;
    logic       m_err;
    logic [7:0] tbl [16] = '{8'h06, 8'h06, 8'h05, 8'h05, 8'h04, 8'h29, 8'h29, 8'h29,
                             8'h29, 8'h28, 8'h28, 8'h28, 8'h28, 8'h28, 8'h28, 8'h4C};
    int         stall_seq [11] = '{0, 3, 0, 0, 4, 0, 5, 0, 0, 0, 6};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference codeword from the codebook definition
    function automatic tok_t mk_tok(input int v, input int prev, input bit last);
        tok_t       t;
        logic [7:0] cb;
        int         sw, eo, ro, fe, u, e;
        cb = tbl[(prev > 15) ? 15 : prev];
        sw = int'(cb[1:0]);
        eo = int'(cb[4:2]);
        ro = int'(cb[7:5]);
        fe = (sw + 1) << ro;
        t  = '0;
        if (v < fe) begin
            t.code = CW_W'((1 << ro) + (v % (1 << ro)));
            t.len  = LEN_W'((v >> ro) + 1 + ro);
        end else begin
            u = v - fe + (1 << eo);
            e = 0;
            while ((u >> (e + 1)) != 0) e++;
            t.code = CW_W'(u);
            t.len  = LEN_W'(2 * e + 1 - eo + sw);
        end
        t.last = last;
        return t;
    endfunction

    function automatic void model_reset();
        m_run  = 0;
        m_prev = 4;
        m_err  = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_beat(input int c, input bit last);
        tok_t mk;
        if (c != 0) begin
            exp_q.push_back(mk_tok(m_run, m_prev, last));
            m_prev = m_run;
            m_run  = 0;
        end else begin
            if (m_run == RUN_MAX) m_err = 1'b1;
            else                  m_run++;
            if (last) begin
                mk      = '0;
                mk.last = 1'b1;
                exp_q.push_back(mk);
            end
        end
        if (last) begin
            m_run  = 0;
            m_prev = 4;
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic send(input int c, input bit last);
        int guard;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.in_coeff = COEFF_W'(c);
        bus.in_last  = last;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        model_beat(c, last);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_coeff = '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            mon_got.code = bus.out_code;
            mon_got.len  = bus.out_len;
            mon_got.last = bus.out_last;
            if (exp_q.size() == 0) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL extra_token observed=%0h expected=none", mon_got);
                end
            end else begin
                mon_want = exp_q.pop_front();
                chk("tok_code", 64'(mon_got.code), 64'(mon_want.code));
                chk("tok_len",  64'(mon_got.len),  64'(mon_want.len));
                chk("tok_last", 64'(mon_got.last), 64'(mon_want.last));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_coeff  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_code",  64'(bus.out_code),  64'd0);
        chk("rst_out_len",   64'(bus.out_len),   64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_err",       64'(err_run_ovf),   64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 5,7: first token from prev_run=4, plus 2-cycle latency
        send(5, 1'b0);
        @(negedge clk);
        chk("latency_c1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("latency_c2", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        send(7, 1'b1);
        drain("drain_5_7");

        // 5,0,0,9: rice with q=2
        send(5, 1'b0); send(0, 1'b0); send(0, 1'b0); send(9, 1'b1);
        drain("drain_rice");

        // 3, seven zeros, 8: exp-golomb branch
        send(3, 1'b0);
        for (int i = 0; i < 7; i++) send(0, 1'b0);
        send(8, 1'b1);
        drain("drain_expg");

        // trailing zeros -> marker, then restart with prev_run=4
        send(4, 1'b0); send(0, 1'b0); send(0, 1'b1);
        send(6, 1'b1);
        drain("drain_marker");

        // mixed runs covering the larger codebooks
        for (int t = 0; t < 14; t++) begin
            int r;
            r = int'($urandom_range(0, 22));
            for (int z = 0; z < r; z++) send(0, 1'b0);
            send((t % 2 == 1) ? -3 : 17 + t, t == 13);
        end
        drain("drain_mixed");
        chk("err_mixed", 64'(err_run_ovf), 64'(m_err));

        // backpressure: pipe fills, in_ready drops, tokens survive in order
        bus.out_ready = 1'b0;
        send(1, 1'b0);
        send(2, 1'b0);
        @(negedge clk);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 11; i++) send(stall_seq[i], i == 10);
            end
        join
        drain("drain_stall");
        repeat (2) @(negedge clk);
        chk("stall_no_dup", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // reset with two tokens in flight and prev_run != 4
        bus.out_ready = 1'b0;
        send(0, 1'b0); send(0, 1'b0); send(5, 1'b0); send(6, 1'b0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        send(0, 1'b0); send(0, 1'b0); send(9, 1'b1);
        drain("drain_midrst");

        // run saturation at 2^RUN_W-1 and sticky error
        chk("err_before_sat", 64'(err_run_ovf), 64'd0);
        for (int i = 0; i < RUN_MAX + 5; i++) send(0, 1'b0);
        send(1, 1'b1);
        drain("drain_sat");
        chk("err_after_sat", 64'(err_run_ovf), 64'd1);
        chk("err_model_sat", 64'(err_run_ovf), 64'(m_err));
        send(3, 1'b1);
        drain("drain_sticky");
        chk("err_sticky", 64'(err_run_ovf), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
